// File: rtl/veririsc_pkg.sv
// Purpose : shared VeriRISC constants for the controller, ALU and test bench.
// Latency : n/a (types, constants and a pure decode helper only).
// Backpr. : n/a.
// Contents: opcode_t (HLT..JMP), phase_t (INST_ADDR..STORE), ctrl_t output bundle,
//           is_aluop() helper.
package veririsc_pkg;

    localparam int OPCODE_W   = 3;
    localparam int PHASE_W    = 3;
    localparam int NUM_PHASES = 8;

    typedef enum logic [OPCODE_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    // Non-halt control strobes, grouped so the halted override is a single mux.
    typedef struct packed {
        logic sel;
        logic rd;
        logic wr;
        logic ld_ir;
        logic ld_ac;
        logic ld_pc;
        logic inc_pc;
        logic data_e;
    } ctrl_t;

    // Opcodes that read an operand from memory and load the accumulator.
    function automatic logic is_aluop(input opcode_t op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/veririsc_phase_counter.sv
// Purpose : 3-bit wrapping instruction-phase counter with hold.
// Latency : phase updates one clock after the edge; hold freezes it in place.
// Backpr. : none; hold is the only stall source.
// Ports   : clk, rst_n (async active-low clear to 0), hold, phase[2:0].
module veririsc_phase_counter
    import veririsc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    output logic [PHASE_W-1:0] phase
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    // Natural 3-bit overflow gives the 7 -> 0 wrap.
    always_comb begin
        phase_d = phase_q;
        if (!hold) begin
            phase_d = phase_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/veririsc_controller.sv
// Purpose : VeriRISC sequencing controller; decodes phase + opcode into datapath strobes.
// Latency : strobes are combinational from phase/opcode (zero added latency); halt is registered.
// Backpr. : none; once HLT is decoded the phase freezes until rst_n is asserted.
// Ports   : clk, rst_n, opcode[2:0], zero -> sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt.
module veririsc_controller
    import veririsc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                wr,
    output logic                ld_ir,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                inc_pc,
    output logic                data_e,
    output logic                halt
);

    opcode_t            op;
    phase_t             phase;
    logic [PHASE_W-1:0] phase_raw;
    logic               alu_op;
    logic               halted_q;
    logic               halted_d;
    ctrl_t              dec;
    ctrl_t              ctrl;

    assign op     = opcode_t'(opcode);
    assign phase  = phase_t'(phase_raw);
    assign alu_op = is_aluop(op);

    // Holding on halted_q (not on the HLT decode) lets the counter take its
    // normal OP_ADDR -> OP_FETCH step on the halting edge, then freeze there.
    veririsc_phase_counter u_phase_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (halted_q),
        .phase (phase_raw)
    );

    // Phase/opcode decode. Only the current-cycle opcode is used, so a
    // changing opcode never perturbs the phase sequence.
    always_comb begin
        dec = '0;
        case (phase)
            INST_ADDR: begin
                dec.sel = 1'b1;
            end
            INST_FETCH: begin
                dec.sel = 1'b1;
                dec.rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                dec.sel   = 1'b1;
                dec.rd    = 1'b1;
                dec.ld_ir = 1'b1;
            end
            OP_ADDR: begin
                dec.inc_pc = 1'b1;
            end
            OP_FETCH: begin
                dec.rd = alu_op;
            end
            ALU_OP: begin
                dec.rd     = alu_op;
                dec.inc_pc = (op == SKZ) && zero;
                dec.ld_pc  = (op == JMP);
                dec.data_e = (op == STO);
            end
            STORE: begin
                // rd is ALU-only and wr is STO-only, so they never overlap;
                // wr always coincides with data_e.
                dec.rd     = alu_op;
                dec.ld_ac  = alu_op;
                dec.ld_pc  = (op == JMP);
                dec.wr     = (op == STO);
                dec.data_e = (op == STO);
            end
            default: begin
                dec = '0;
            end
        endcase
    end

    // While halted every strobe except halt is forced low.
    always_comb begin
        ctrl = dec;
        if (halted_q) begin
            ctrl = '0;
        end
    end

    // Halted state: entered on the edge that ends an OP_ADDR cycle holding HLT,
    // left only through reset.
    always_comb begin
        halted_d = halted_q;
        if ((phase == OP_ADDR) && (op == HLT)) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign sel    = ctrl.sel;
    assign rd     = ctrl.rd;
    assign wr     = ctrl.wr;
    assign ld_ir  = ctrl.ld_ir;
    assign ld_ac  = ctrl.ld_ac;
    assign ld_pc  = ctrl.ld_pc;
    assign inc_pc = ctrl.inc_pc;
    assign data_e = ctrl.data_e;
    assign halt   = halted_q;

endmodule

// File: tb/tb_veririsc_controller.sv
// Purpose : scoreboard bench for veririsc_controller with hand-computed per-phase strobe vectors.
// Latency : expectations pushed at posedge+1, checked at negedge+1 and on every rst_n fall.
// Backpr. : n/a.
`timescale 1ns/1ps
module tb_veririsc_controller;
    import veririsc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] opcode;
    logic       zero;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [8:0] obs;

    always #5 clk = ~clk;

    veririsc_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .halt   (halt)
    );

    assign obs = {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt};

    // Output bit masks, in obs order.
    localparam logic [8:0] NONE  = 9'h000;
    localparam logic [8:0] SEL   = 9'h100;
    localparam logic [8:0] RD    = 9'h080;
    localparam logic [8:0] WR    = 9'h040;
    localparam logic [8:0] LDIR  = 9'h020;
    localparam logic [8:0] LDAC  = 9'h010;
    localparam logic [8:0] LDPC  = 9'h008;
    localparam logic [8:0] INC   = 9'h004;
    localparam logic [8:0] DE    = 9'h002;
    localparam logic [8:0] HALTB = 9'h001;

    typedef struct {
        logic [8:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    task automatic expect_out(input logic [8:0] e, input string n);
        exp_t x;
        x.exp  = e;
        x.name = n;
        exp_q.push_back(x);
    endtask

    // Drive one cycle's inputs, queue its expected strobes, advance to posedge+1.
    task automatic cycle(input logic [2:0] op, input logic z, input logic [8:0] e, input string n);
        opcode = op;
        zero   = z;
        expect_out(e, n);
        @(posedge clk);
        #1;
    endtask

    // Phases 0..3 are opcode-independent.
    task automatic fetch(input logic [2:0] op, input string n);
        cycle(op, 1'b0, SEL,             {n, "_p0"});
        cycle(op, 1'b0, SEL | RD,        {n, "_p1"});
        cycle(op, 1'b0, SEL | RD | LDIR, {n, "_p2"});
        cycle(op, 1'b0, SEL | RD | LDIR, {n, "_p3"});
    endtask

    task automatic instr(input logic [2:0] op, input logic z, input string n,
                         input logic [8:0] e4, input logic [8:0] e5,
                         input logic [8:0] e6, input logic [8:0] e7);
        fetch(op, n);
        cycle(op, z, e4, {n, "_p4"});
        cycle(op, z, e5, {n, "_p5"});
        cycle(op, z, e6, {n, "_p6"});
        cycle(op, z, e7, {n, "_p7"});
    endtask

    // Monitor: compares whenever the DUT presents a settled output.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (mon_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL underflow: got %b with no expected value queued", obs);
                end else begin
                    x = exp_q.pop_front();
                    if (obs !== x.exp) begin
                        errors++;
                        $display("FAIL %s: got %b required %b (sel rd wr ld_ir ld_ac ld_pc inc_pc data_e halt)",
                                 x.name, obs, x.exp);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL timeout: bench did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n  = 1'b0;
        opcode = ADD;
        zero   = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held across two edges: phase stays at INST_ADDR.
        cycle(ADD, 1'b0, SEL, "reset_a");
        cycle(ADD, 1'b0, SEL, "reset_b");
        rst_n = 1'b1;

        instr(ADD, 1'b0, "add", INC, RD,   RD,   RD | LDAC);
        instr(STO, 1'b0, "sto", INC, NONE, DE,   WR | DE);
        instr(SKZ, 1'b1, "skz1", INC, NONE, INC,  NONE);
        instr(SKZ, 1'b0, "skz0", INC, NONE, NONE, NONE);
        instr(AND, 1'b1, "and", INC, RD,   RD,   RD | LDAC);

        // Opcode changes every cycle of the execute half; sequence is unaffected.
        fetch(STO, "mix");
        cycle(JMP, 1'b0, INC,       "mix_p4");
        cycle(ADD, 1'b0, RD,        "mix_p5");
        cycle(STO, 1'b0, DE,        "mix_p6");
        cycle(ADD, 1'b0, RD | LDAC, "mix_p7");

        instr(JMP, 1'b1, "jmp", INC, NONE, LDPC, LDPC);

        // JMP aborted by asynchronous reset in ALU_OP, checked before the next edge.
        fetch(JMP, "jrst");
        cycle(JMP, 1'b0, INC,  "jrst_p4");
        cycle(JMP, 1'b0, NONE, "jrst_p5");
        opcode = JMP;
        expect_out(LDPC, "jrst_p6");
        @(negedge clk);
        #2;
        expect_out(SEL, "jrst_async_reset");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        instr(XOR, 1'b0, "xor_after_rst", INC, RD, RD, RD | LDAC);

        // HLT: inc_pc in OP_ADDR, then frozen with only halt high.
        fetch(HLT, "hlt");
        cycle(HLT, 1'b0, INC, "hlt_p4");
        for (int i = 0; i < 20; i++) begin
            cycle(3'(i % 8), 1'(i % 2), HALTB, $sformatf("halted_%0d", i));
        end

        // Reset pulse from HALTED; checked at the falling edge and again while held.
        expect_out(SEL, "hlt_rst_async");
        rst_n = 1'b0;
        expect_out(SEL, "hlt_rst_held");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        instr(LDA, 1'b0, "lda_after_hlt", INC, RD, RD, RD | LDAC);

        mon_en = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d expected values never checked, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
